// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
// Conversions work on a wide word; callers size-cast to their pointer width.
package fifo_pkg;

    localparam int ADDR_WIDTH_DFLT = 5;
    localparam int DATA_WIDTH_DFLT = 8;
    localparam int PTR_MAX         = 32;

    typedef logic [PTR_MAX-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended Gray input keeps the upper result bits zero.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_read_port_if.sv
// Downstream valid/ready stream presented by the FIFO read port.
interface fifo_read_port_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-stage flop synchroniser for Gray-coded pointers crossing clock domains.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1_reg;
    logic [WIDTH-1:0] q2_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q1_reg <= '0;
            q2_reg <= '0;
        end else begin
            q1_reg <= d;
            q2_reg <= q1_reg;
        end
    end

    assign q = q2_reg;

endmodule

// File: rtl/fifo_read_port.sv
// Read-domain side of the async FIFO: pointer sync, empty/level flags, RAM read
// control and a 2-entry skid buffer giving a first-word-fall-through stream.
module fifo_read_port
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    fifo_read_port_if.master      m_if,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rd_level
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wq2;
    logic [PW-1:0]         wptr_bin_s;
    logic [PW-1:0]         rd_ptr_bin_reg;
    logic [PW-1:0]         rd_ptr_bin_next;
    logic [PW-1:0]         rd_ptr_gray_reg;
    logic [PW-1:0]         rd_ptr_gray_next;
    logic                  empty_reg;
    logic [PW-1:0]         rd_level_reg;
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;
    logic                  inflight_reg;
    logic [DATA_WIDTH-1:0] skid_reg [2];
    logic                  pop;
    logic                  push;
    logic [2:0]            pending;

    sync_2ff #(
        .WIDTH (PW)
    ) u_wptr_sync (
        .clk   (rd_clk),
        .rst_n (rst_n),
        .d     (wr_ptr_gray),
        .q     (wq2)
    );

    assign wptr_bin_s = PW'(gray2bin(ptr_word_t'(wq2)));

    assign pop  = (occ_reg != 2'd0) & m_if.m_ready;
    assign push = inflight_reg;

    // Words already held or on their way, after this cycle's pop; a new read
    // is only launched when it is guaranteed a free skid slot.
    assign pending = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign mem_ren = rst_n & ~empty_reg & (pending < 3'd2);

    assign rd_ptr_bin_next  = rd_ptr_bin_reg + {{ADDR_WIDTH{1'b0}}, mem_ren};
    assign rd_ptr_gray_next = PW'(bin2gray(ptr_word_t'(rd_ptr_bin_next)));
    assign occ_next         = occ_reg + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            rd_ptr_bin_reg  <= '0;
            rd_ptr_gray_reg <= '0;
            empty_reg       <= 1'b1;
            rd_level_reg    <= '0;
            occ_reg         <= 2'd0;
            inflight_reg    <= 1'b0;
            skid_reg[0]     <= '0;
            skid_reg[1]     <= '0;
        end else begin
            rd_ptr_bin_reg  <= rd_ptr_bin_next;
            rd_ptr_gray_reg <= rd_ptr_gray_next;
            // Comparing the post-read pointer stops a second read of the last word.
            empty_reg       <= (rd_ptr_gray_next == wq2);
            rd_level_reg    <= wptr_bin_s - rd_ptr_bin_next;
            inflight_reg    <= mem_ren;
            occ_reg         <= occ_next;
            if (pop) begin
                skid_reg[0] <= skid_reg[1];
            end
            if (push) begin
                if ((occ_reg == 2'd0) || ((occ_reg == 2'd1) && pop)) begin
                    skid_reg[0] <= mem_rdata;
                end else begin
                    skid_reg[1] <= mem_rdata;
                end
            end
        end
    end

    assign m_if.m_valid = (occ_reg != 2'd0);
    assign m_if.m_data  = skid_reg[0];
    assign rd_ptr_gray  = rd_ptr_gray_reg;
    assign mem_raddr    = rd_ptr_bin_reg[ADDR_WIDTH-1:0];
    assign empty        = empty_reg;
    assign rd_level     = rd_level_reg;

endmodule

// File: tb/tb_fifo_read_port.sv
// Bench for fifo_read_port: behavioural RAM and writer, a queue scoreboard of
// written words, cycle tables for latency and directed/random stream sequences.
module tb_fifo_read_port;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] wr_ptr_gray;
    logic [PW-1:0] rd_ptr_gray;
    logic [AW-1:0] mem_raddr;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata;
    logic          empty;
    logic [PW-1:0] rd_level;

    fifo_read_port_if #(.DATA_WIDTH(DW)) m_if ();

    fifo_read_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .rd_clk      (clk),
        .rst_n       (rst_n),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .mem_raddr   (mem_raddr),
        .mem_ren     (mem_ren),
        .mem_rdata   (mem_rdata),
        .m_if        (m_if),
        .empty       (empty),
        .rd_level    (rd_level)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= ram[mem_raddr];
    end

    int          checks   = 0;
    int          failures = 0;
    logic [DW-1:0] sb_q [$];
    int unsigned wptr  = 0;
    int unsigned reads = 0;
    int unsigned pops  = 0;

    typedef struct {
        logic          rdy;
        logic          e_empty;
        logic          e_ren;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [PW-1:0] e_level;
        logic [PW-1:0] e_gray;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [PW-1:0] gray(input int unsigned n);
        logic [PW-1:0] b;
        b = n[PW-1:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        ram[wptr[AW-1:0]] = d;
        sb_q.push_back(d);
        wptr++;
        wr_ptr_gray = gray(wptr);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    // Scoreboard and safety monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            reads = 0;
            pops  = 0;
        end else begin
            if (mem_ren) begin
                reads++;
                check("read_when_empty", 32'(reads <= wptr), 1);
            end
            if (m_if.m_valid && m_if.m_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pop", 0, 1);
                end else begin
                    check("pop_data", m_if.m_data, sb_q[0]);
                    $display("POP %0d data=%02h", pops, m_if.m_data);
                    void'(sb_q.pop_front());
                end
                pops++;
            end
            if (mem_ren || (m_if.m_valid && m_if.m_ready))
                check("skid_overflow", 32'((reads - pops) <= 2), 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp4 [4];
        logic          seen;
        int            n;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 6'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 6'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 6'd1, 6'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 6'd1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 6'd0, 6'd1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 6'd1};

        // Reset then idle
        rst_n       = 1'b0;
        m_if.m_ready = 1'b0;
        wr_ptr_gray = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        #1;
        check("rst_empty", empty, 1);
        check("rst_valid", m_if.m_valid, 0);
        check("rst_ren", mem_ren, 0);
        check("rst_level", rd_level, 0);
        check("rst_gray", rd_ptr_gray, 0);
        check("rst_data", m_if.m_data, 0);

        // Single word latency table
        tick();
        m_if.m_ready = 1'b1;
        write_word(8'hA5);
        for (int k = 0; k < 6; k++) begin
            tick();
            m_if.m_ready = tbl[k].rdy;
            #1;
            check("lat_empty", empty, tbl[k].e_empty);
            check("lat_ren", mem_ren, tbl[k].e_ren);
            check("lat_valid", m_if.m_valid, tbl[k].e_valid);
            if (tbl[k].e_valid) check("lat_data", m_if.m_data, tbl[k].e_data);
            check("lat_level", rd_level, tbl[k].e_level);
            check("lat_gray", rd_ptr_gray, tbl[k].e_gray);
            $display("VEC edge=%0d empty=%0b ren=%0b valid=%0b data=%02h level=%0d gray=%0h",
                     k + 1, empty, mem_ren, m_if.m_valid, m_if.m_data, rd_level, rd_ptr_gray);
        end

        // Backpressure: two reads fill the skid, head held stable
        exp4[0] = 8'hAA; exp4[1] = 8'hBB; exp4[2] = 8'hCC; exp4[3] = 8'hDD;
        tick();
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(exp4[i]);
        repeat (10) tick();
        #1;
        check("bp_valid", m_if.m_valid, 1);
        check("bp_data", m_if.m_data, 8'hAA);
        check("bp_level", rd_level, 2);
        check("bp_ren", mem_ren, 0);
        check("bp_gray", rd_ptr_gray, gray(3));
        repeat (3) begin
            tick();
            #1;
            check("bp_hold", m_if.m_data, 8'hAA);
        end
        tick();
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_seq_valid", m_if.m_valid, 1);
            check("bp_seq_data", m_if.m_data, exp4[i]);
            tick();
        end
        #1;
        check("bp_done_valid", m_if.m_valid, 0);

        // Bring read pointer to 30, then fill the FIFO completely across the wrap
        tick();
        for (int i = 0; i < 25; i++) begin
            write_word(DW'($urandom));
            tick();
        end
        wait_drain(200);
        repeat (4) tick();
        check("pre_wrap_gray", rd_ptr_gray, gray(30));
        m_if.m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_word(DW'($urandom));
        n = 0;
        while (empty && n < 20) begin
            tick();
            n++;
        end
        check("full_empty_fall", empty, 0);
        check("full_level", rd_level, DEPTH);
        m_if.m_ready = 1'b1;
        n = 0;
        while (!m_if.m_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("wrap_stream_valid", m_if.m_valid, 1);
            tick();
        end
        #1;
        check("wrap_end_valid", m_if.m_valid, 0);
        check("wrap_end_empty", empty, 1);
        check("wrap_end_level", rd_level, 0);
        check("wrap_end_gray", rd_ptr_gray, gray(62));

        // Reset mid-stream
        tick();
        for (int i = 0; i < 20; i++) write_word(DW'($urandom));
        repeat (8) tick();
        rst_n       = 1'b0;
        wr_ptr_gray = '0;
        wptr        = 0;
        sb_q.delete();
        #1;
        check("rst_mid_ren", mem_ren, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_mid_valid", m_if.m_valid, 0);
        check("rst_mid_gray", rd_ptr_gray, 0);
        check("rst_mid_empty", empty, 1);
        check("rst_mid_level", rd_level, 0);
        check("rst_mid_data", m_if.m_data, 0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (m_if.m_valid) seen = 1'b1;
        end
        check("rst_mid_no_stale", seen, 0);

        // Random ready with continuous writes
        for (int c = 0; c < 3000; c++) begin
            tick();
            m_if.m_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0 && (wptr - pops) < DEPTH)
                write_word(DW'($urandom));
        end
        tick();
        m_if.m_ready = 1'b1;
        wait_drain(300);
        repeat (5) tick();
        #1;
        check("rand_end_empty", empty, 1);
        check("rand_end_level", rd_level, 0);
        check("rand_end_valid", m_if.m_valid, 0);
        check("rand_end_gray", rd_ptr_gray, gray(wptr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
